// File: rtl/cpu_types_pkg.sv
// Shared datapath/memory types: word, RAM handshake state and arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  localparam int         ERR_CNT_W   = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while an instruction fetch waits.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = 4'd0;
    else if (inc && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= 4'd0;
    else
      cnt_q <= cnt_d;
  end

  assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data port; data has
// priority except when the starvation counter forces an instruction grant.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic [7:0] err_cnt
);

  arb_state_t state_q, state_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic       ren_q, ren_d;
  logic       wen_q, wen_d;
  logic [7:0] err_q, err_d;

  logic dreq, win_req, starve_inc, starve_clr, starve_sat;
  logic i_done, d_done;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk (CLK),
    .rst (RST),
    .inc (starve_inc),
    .clr (starve_clr),
    .sat (starve_sat)
  );

  assign dreq    = dREN | dWEN;
  // The winner still holding its request is what keeps the access alive.
  assign win_req = ((state_q == IGRANT) && iREN) || ((state_q == DGRANT) && dreq);
  assign i_done  = (state_q == IGRANT) && iREN && (ramstate == ACCESS);
  assign d_done  = (state_q == DGRANT) && dreq && (ramstate == ACCESS);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    ren_d      = ren_q;
    wen_d      = wen_q;
    err_d      = err_q;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    case (state_q)
      IDLE: begin
        starve_clr = !iREN;
        if (dreq && !(iREN && starve_sat)) begin
          state_d    = DGRANT;
          addr_d     = daddr;
          store_d    = dstore;
          ren_d      = !dWEN;
          wen_d      = dWEN;
          starve_inc = iREN;
        end else if (iREN) begin
          state_d    = IGRANT;
          addr_d     = iaddr;
          store_d    = '0;
          ren_d      = 1'b1;
          wen_d      = 1'b0;
          starve_clr = 1'b1;
        end
      end
      IGRANT, DGRANT: begin
        // Abort and completion both return to IDLE; ERROR retries in place.
        if (!win_req || (ramstate == ACCESS)) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end else if ((ramstate == ERROR) && (err_q != ERR_CNT_MAX)) begin
          err_d = err_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
    end
  end

  // Strobes fall in the same cycle a winner withdraws its request.
  assign ramREN   = ren_q & win_req;
  assign ramWEN   = wen_q & win_req;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign err_cnt  = err_q;

  assign iwait = !i_done;
  assign dwait = !d_done;
  assign iload = i_done ? ramload : '0;
  assign dload = (d_done && !wen_q) ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, starvation, retry, abort, reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic       CLK, RST;
  logic       iREN, dREN, dWEN;
  word_t      iaddr, daddr, dstore, ramload;
  ramstate_t  ramstate;
  logic       iwait, dwait, ramREN, ramWEN;
  word_t      iload, dload, ramaddr, ramstore;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err_cnt(err_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    cyc();
    #1;
    chk("rst_iwait",   32'(iwait),   32'd1);
    chk("rst_dwait",   32'(dwait),   32'd1);
    chk("rst_ramREN",  32'(ramREN),  32'd0);
    chk("rst_ramWEN",  32'(ramWEN),  32'd0);
    chk("rst_ramaddr", ramaddr,      32'd0);
    chk("rst_ramstore",ramstore,     32'd0);
    chk("rst_iload",   iload,        32'd0);
    chk("rst_dload",   dload,        32'd0);
    chk("rst_err",     32'(err_cnt), 32'd0);
    cyc();
    RST = 1'b0;

    // Single fetch, minimum latency.
    cyc(); iREN = 1; iaddr = 32'h40; ramstate = FREE; #1;
    chk("f_idle_iwait", 32'(iwait), 32'd1);
    chk("f_idle_ren",   32'(ramREN), 32'd0);
    cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("f_iwait", 32'(iwait), 32'd0);
    chk("f_iload", iload, 32'hDEADBEEF);
    chk("f_addr",  ramaddr, 32'h40);
    chk("f_ren",   32'(ramREN), 32'd1);
    cyc(); iREN = 0; ramstate = FREE; #1;
    chk("f_back_ren",   32'(ramREN), 32'd0);
    chk("f_back_iwait", 32'(iwait), 32'd1);

    // Fetch and write together: data first, fetch after.
    cyc(); iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678; #1;
    cyc(); ramstate = ACCESS; ramload = 32'h0; #1;
    chk("p_wen",   32'(ramWEN), 32'd1);
    chk("p_ren",   32'(ramREN), 32'd0);
    chk("p_store", ramstore, 32'h12345678);
    chk("p_addr",  ramaddr, 32'h80);
    chk("p_dwait", 32'(dwait), 32'd0);
    chk("p_iwait", 32'(iwait), 32'd1);
    chk("p_dload", dload, 32'd0);
    cyc(); dWEN = 0; ramstate = FREE; #1;
    chk("p_idle_wen", 32'(ramWEN), 32'd0);
    cyc(); ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    chk("p_f_ren",   32'(ramREN), 32'd1);
    chk("p_f_addr",  ramaddr, 32'h44);
    chk("p_f_iwait", 32'(iwait), 32'd0);
    chk("p_f_iload", iload, 32'hCAFEF00D);
    cyc(); iREN = 0; ramstate = FREE; #1;

    // Starvation: four data grants, then the fetch, then data again.
    cyc(); iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h200; #1;
    for (int g = 1; g <= 6; g++) begin
      cyc(); ramstate = ACCESS; ramload = 32'(g); #1;
      if (g == 5) begin
        chk("s_igrant_addr",  ramaddr, 32'h100);
        chk("s_igrant_iwait", 32'(iwait), 32'd0);
        chk("s_igrant_dwait", 32'(dwait), 32'd1);
      end else begin
        chk($sformatf("s_d%0d_addr", g),  ramaddr, 32'h200);
        chk($sformatf("s_d%0d_dwait", g), 32'(dwait), 32'd0);
        chk($sformatf("s_d%0d_iwait", g), 32'(iwait), 32'd1);
        chk($sformatf("s_d%0d_dload", g), dload, 32'(g));
      end
      cyc(); ramstate = FREE;
      if (g == 5) iaddr = 32'h104;
      if (g == 6) begin iREN = 0; dREN = 0; end
      #1;
      chk($sformatf("s_idle%0d_ren", g), 32'(ramREN), 32'd0);
    end

    // Read with BUSY, BUSY, ERROR, ACCESS.
    cyc(); dREN = 1; daddr = 32'h300; #1;
    cyc(); ramstate = BUSY; #1;
    chk("e_b1_dwait", 32'(dwait), 32'd1);
    chk("e_b1_ren",   32'(ramREN), 32'd1);
    cyc(); ramstate = BUSY; #1;
    chk("e_b2_dwait", 32'(dwait), 32'd1);
    cyc(); ramstate = ERROR; #1;
    chk("e_er_dwait", 32'(dwait), 32'd1);
    chk("e_er_ren",   32'(ramREN), 32'd1);
    cyc(); ramstate = ACCESS; ramload = 32'h5A5A5A5A; #1;
    chk("e_ac_dwait", 32'(dwait), 32'd0);
    chk("e_ac_ren",   32'(ramREN), 32'd1);
    chk("e_ac_dload", dload, 32'h5A5A5A5A);
    chk("e_err_cnt",  32'(err_cnt), 32'd1);
    cyc(); dREN = 0; ramstate = FREE; #1;

    // Abort while BUSY.
    cyc(); dREN = 1; daddr = 32'h400; #1;
    cyc(); ramstate = BUSY; #1;
    chk("a_busy_ren", 32'(ramREN), 32'd1);
    cyc(); dREN = 0; #1;
    chk("a_drop_dwait", 32'(dwait), 32'd1);
    cyc(); ramstate = FREE; iREN = 1; iaddr = 32'h480; #1;
    chk("a_idle_ren",   32'(ramREN), 32'd0);
    chk("a_idle_dwait", 32'(dwait), 32'd1);
    cyc(); ramstate = ACCESS; ramload = 32'h11; #1;
    chk("a_next_iwait", 32'(iwait), 32'd0);
    chk("a_next_addr",  ramaddr, 32'h480);
    cyc(); iREN = 0; ramstate = FREE; #1;

    // Reset pulsed during a data write.
    cyc(); dWEN = 1; daddr = 32'h500; dstore = 32'h77; #1;
    cyc(); ramstate = BUSY; #1;
    chk("r_pre_wen", 32'(ramWEN), 32'd1);
    ramstate = ACCESS; RST = 1; #1;
    chk("r_wen",   32'(ramWEN), 32'd0);
    chk("r_ren",   32'(ramREN), 32'd0);
    chk("r_addr",  ramaddr, 32'd0);
    chk("r_store", ramstore, 32'd0);
    chk("r_dwait", 32'(dwait), 32'd1);
    chk("r_iwait", 32'(iwait), 32'd1);
    chk("r_err",   32'(err_cnt), 32'd0);
    dWEN = 0; ramstate = FREE; #1; RST = 0;
    cyc(); iREN = 1; iaddr = 32'h600; #1;
    cyc(); ramstate = ACCESS; ramload = 32'h1234; #1;
    chk("r_f_iwait", 32'(iwait), 32'd0);
    chk("r_f_iload", iload, 32'h1234);
    chk("r_f_addr",  ramaddr, 32'h600);
    cyc(); iREN = 0; ramstate = FREE; #1;

    // Error counter saturation.
    cyc(); dREN = 1; daddr = 32'h700; #1;
    for (int k = 0; k < 300; k++) begin
      cyc(); ramstate = ERROR; #1;
    end
    chk("sat_dwait", 32'(dwait), 32'd1);
    cyc(); ramstate = ACCESS; #1;
    chk("sat_err",   32'(err_cnt), 32'd255);
    chk("sat_done",  32'(dwait), 32'd0);
    cyc(); dREN = 0; ramstate = FREE; #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
